// File: rtl/dec_monitor_if.sv
// Bundle of decoder sample inputs and monitor results shared by dec_monitor and its driver.
// The master side presents samples and clr_err; the slave side reports codes and error state.
interface dec_monitor_if;
  logic [7:0] dec_out;
  logic [7:0] not_dec_out;
  logic       en;
  logic       sample;
  logic       clr_err;
  logic [2:0] code;
  logic       code_valid;
  logic       active;
  logic       err_pair;
  logic       err_onehot;
  logic [7:0] err_cnt;
  logic       sticky_err;
  logic [7:0] hit_map;
  logic       sweep_done;

  modport master (
    output dec_out, not_dec_out, en, sample, clr_err,
    input  code, code_valid, active, err_pair, err_onehot,
    input  err_cnt, sticky_err, hit_map, sweep_done
  );

  modport slave (
    input  dec_out, not_dec_out, en, sample, clr_err,
    output code, code_valid, active, err_pair, err_onehot,
    output err_cnt, sticky_err, hit_map, sweep_done
  );
endinterface

// File: rtl/dec_monitor.sv
// Two-stage checker for a 3-to-8 decoder: stage 1 captures a strobed sample, stage 2 reports
// the encoded line, pairing/line-count errors, a saturating error count and a coverage map.
module dec_monitor (
  input  logic          clk,
  input  logic          rst,
  dec_monitor_if.slave  bus
);

  logic       s1_valid_q, s1_valid_d;
  logic [7:0] s1_dec_q, s1_dec_d;
  logic [7:0] s1_ndec_q, s1_ndec_d;
  logic       s1_en_q, s1_en_d;

  logic [2:0] code_q, code_d;
  logic       code_valid_q, code_valid_d;
  logic       active_q, active_d;
  logic       err_pair_q, err_pair_d;
  logic       err_onehot_q, err_onehot_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       sticky_err_q, sticky_err_d;
  logic [7:0] hit_map_q, hit_map_d;

  logic [2:0] calc_code;
  logic [3:0] calc_ones;
  logic       calc_active;
  logic       calc_pair;
  logic       calc_onehot;
  logic       calc_err;

  // Evaluation of the captured sample; only consumed when s1_valid_q is set.
  always_comb begin
    calc_code = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (s1_dec_q[i]) calc_code = 3'(i);
    end
    calc_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      calc_ones = calc_ones + {3'b000, s1_dec_q[i]};
    end
    calc_active = |s1_dec_q;
    calc_pair   = |(s1_dec_q ~^ s1_ndec_q);
    calc_onehot = s1_en_q ? (calc_ones != 4'd1) : calc_active;
    calc_err    = calc_pair | calc_onehot;
  end

  always_comb begin
    s1_valid_d   = bus.sample;
    s1_dec_d     = s1_dec_q;
    s1_ndec_d    = s1_ndec_q;
    s1_en_d      = s1_en_q;
    code_valid_d = s1_valid_q;
    code_d       = code_q;
    active_d     = active_q;
    err_pair_d   = err_pair_q;
    err_onehot_d = err_onehot_q;
    err_cnt_d    = err_cnt_q;
    sticky_err_d = sticky_err_q;
    hit_map_d    = hit_map_q;

    if (bus.sample) begin
      s1_dec_d  = bus.dec_out;
      s1_ndec_d = bus.not_dec_out;
      s1_en_d   = bus.en;
    end

    if (s1_valid_q) begin
      code_d       = calc_code;
      active_d     = calc_active;
      err_pair_d   = calc_pair;
      err_onehot_d = calc_onehot;
    end

    // clr_err takes priority and discards any accounting for the sample reported this edge.
    if (bus.clr_err) begin
      err_cnt_d    = 8'h00;
      sticky_err_d = 1'b0;
      hit_map_d    = 8'h00;
    end else if (s1_valid_q) begin
      if (calc_err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        sticky_err_d = 1'b1;
      end else if (s1_en_q) begin
        hit_map_d = hit_map_q | (8'd1 << calc_code);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_dec_q     <= 8'h00;
      s1_ndec_q    <= 8'h00;
      s1_en_q      <= 1'b0;
      code_q       <= 3'd0;
      code_valid_q <= 1'b0;
      active_q     <= 1'b0;
      err_pair_q   <= 1'b0;
      err_onehot_q <= 1'b0;
      err_cnt_q    <= 8'h00;
      sticky_err_q <= 1'b0;
      hit_map_q    <= 8'h00;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_dec_q     <= s1_dec_d;
      s1_ndec_q    <= s1_ndec_d;
      s1_en_q      <= s1_en_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      active_q     <= active_d;
      err_pair_q   <= err_pair_d;
      err_onehot_q <= err_onehot_d;
      err_cnt_q    <= err_cnt_d;
      sticky_err_q <= sticky_err_d;
      hit_map_q    <= hit_map_d;
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.active     = active_q;
  assign bus.err_pair   = err_pair_q;
  assign bus.err_onehot = err_onehot_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.sticky_err = sticky_err_q;
  assign bus.hit_map    = hit_map_q;
  assign bus.sweep_done = &hit_map_q;

endmodule

// File: tb/tb_dec_monitor.sv
// Bench for dec_monitor: directed vector table, corner-case sequences and random samples,
// all observed by a cycle-indexed reference model of the reporting behaviour.
module tb_dec_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec_monitor_if bus();

  dec_monitor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of driven inputs per cycle plus the architectural result state.
  logic       h_smp [8];
  logic [7:0] h_dec [8];
  logic [7:0] h_ndec[8];
  logic       h_en  [8];
  logic       h_clr [8];
  logic [2:0] m_code;
  logic       m_active, m_pair, m_oh, m_sticky;
  logic [7:0] m_cnt, m_hit;

  function automatic logic [2:0] lowest_line(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(negedge clk) begin
    int ps;
    int pc;
    logic bad;
    if (rst) begin
      m_code = 3'd0; m_active = 1'b0; m_pair = 1'b0; m_oh = 1'b0;
      m_sticky = 1'b0; m_cnt = 8'h00; m_hit = 8'h00;
      for (int i = 0; i < 8; i++) begin
        h_smp[i] = 1'b0;
        h_clr[i] = 1'b0;
      end
      chk("reset_outputs",
          {7'd0, bus.code, bus.code_valid, bus.active, bus.err_pair, bus.err_onehot,
           bus.err_cnt, bus.sticky_err, bus.hit_map, bus.sweep_done}, 32'd0);
    end else begin
      ps = (cyc - 2) & 7;
      pc = (cyc - 1) & 7;
      if (h_smp[ps]) begin
        m_code   = lowest_line(h_dec[ps]);
        m_active = (h_dec[ps] != 8'h00);
        m_pair   = ((h_dec[ps] ^ h_ndec[ps]) != 8'hFF);
        m_oh     = h_en[ps] ? ($countones(h_dec[ps]) != 1) : (h_dec[ps] != 8'h00);
      end
      bad = m_pair | m_oh;
      if (h_clr[pc]) begin
        m_cnt = 8'h00; m_sticky = 1'b0; m_hit = 8'h00;
      end else if (h_smp[ps]) begin
        if (bad) begin
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          m_sticky = 1'b1;
        end else if (h_en[ps]) begin
          m_hit[m_code] = 1'b1;
        end
      end
      chk("code_valid", {31'd0, bus.code_valid}, {31'd0, h_smp[ps]});
      chk("code", {29'd0, bus.code}, {29'd0, m_code});
      chk("flags", {29'd0, bus.active, bus.err_pair, bus.err_onehot},
          {29'd0, m_active, m_pair, m_oh});
      chk("err_cnt", {24'd0, bus.err_cnt}, {24'd0, m_cnt});
      chk("sticky_err", {31'd0, bus.sticky_err}, {31'd0, m_sticky});
      chk("hit_map", {24'd0, bus.hit_map}, {24'd0, m_hit});
      chk("sweep_done", {31'd0, bus.sweep_done}, {31'd0, (m_hit == 8'hFF)});
    end
    h_smp[cyc & 7]  = bus.sample & ~rst;
    h_dec[cyc & 7]  = bus.dec_out;
    h_ndec[cyc & 7] = bus.not_dec_out;
    h_en[cyc & 7]   = bus.en;
    h_clr[cyc & 7]  = bus.clr_err & ~rst;
  end

  task automatic step(input logic s, input logic [7:0] d, input logic [7:0] nd,
                      input logic e, input logic c);
    @(posedge clk);
    #1;
    bus.sample      = s;
    bus.dec_out     = d;
    bus.not_dec_out = nd;
    bus.en          = e;
    bus.clr_err     = c;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] dec;
    logic [7:0] ndec;
    logic       en;
    logic [2:0] code;
    logic       active;
    logic       pair;
    logic       oh;
  } vec_t;

  vec_t tv[7];

  initial begin
    logic [7:0] d, nd;
    tv[0] = '{8'h20, 8'hDF, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
    tv[1] = '{8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{8'h03, 8'hFC, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{8'h01, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0};
    tv[4] = '{8'h80, 8'h7F, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
    tv[5] = '{8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
    tv[6] = '{8'h04, 8'hFB, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};

    bus.sample = 1'b0; bus.dec_out = 8'h00; bus.not_dec_out = 8'hFF;
    bus.en = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors, each reported two cycles after its sample.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, tv[i].dec, tv[i].ndec, tv[i].en, 1'b0);
      idle();
      idle();
      @(negedge clk);
      chk("tv_valid", {31'd0, bus.code_valid}, 32'd1);
      chk("tv_code", {29'd0, bus.code}, {29'd0, tv[i].code});
      chk("tv_flags", {29'd0, bus.active, bus.err_pair, bus.err_onehot},
          {29'd0, tv[i].active, tv[i].pair, tv[i].oh});
      if (i == 0) chk("tv_hit5", {31'd0, bus.hit_map[5]}, 32'd1);
    end
    chk("tv_err_cnt", {24'd0, bus.err_cnt}, 32'd4);
    chk("tv_sticky", {31'd0, bus.sticky_err}, 32'd1);
    chk("tv_hit_map", {24'd0, bus.hit_map}, 32'hA0);

    // Clear, then sweep every line back to back.
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("clr_hit_map", {24'd0, bus.hit_map}, 32'd0);
    chk("clr_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      d = 8'd1 << i;
      step(1'b1, d, ~d, 1'b1, 1'b0);
    end
    idle();
    idle();
    @(negedge clk);
    chk("sweep_hit_map", {24'd0, bus.hit_map}, 32'hFF);
    chk("sweep_done_set", {31'd0, bus.sweep_done}, 32'd1);
    chk("sweep_last_code", {29'd0, bus.code}, 32'd7);

    // Saturation, then clr_err landing on the final error report.
    for (int i = 0; i < 300; i++) step(1'b1, 8'h03, 8'hFC, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    chk("sat_err_cnt", {24'd0, bus.err_cnt}, 32'hFF);
    idle();
    @(negedge clk);
    chk("clr_win_cnt", {24'd0, bus.err_cnt}, 32'd0);
    chk("clr_win_sticky", {31'd0, bus.sticky_err}, 32'd0);

    // Put some state in place, then reset while a sample is in flight.
    step(1'b1, 8'h40, 8'hBF, 1'b1, 1'b0);
    step(1'b1, 8'h06, 8'hF9, 1'b1, 1'b0);
    idle();
    idle();
    step(1'b1, 8'h10, 8'hEF, 1'b1, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("async_rst",
        {7'd0, bus.code, bus.code_valid, bus.active, bus.err_pair, bus.err_onehot,
         bus.err_cnt, bus.sticky_err, bus.hit_map, bus.sweep_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    idle();
    step(1'b1, 8'h08, 8'hF7, 1'b1, 1'b0);
    idle();
    idle();
    @(negedge clk);
    chk("post_rst_first", {28'd0, bus.code_valid, bus.code}, {28'd0, 1'b1, 3'd3});

    // Random samples, checked by the model every cycle.
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 3))
        0:       d = 8'h00;
        1, 2:    d = 8'd1 << $urandom_range(0, 7);
        default: d = 8'($urandom);
      endcase
      nd = ~d;
      if ($urandom_range(0, 5) == 0) nd = nd ^ (8'd1 << $urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, d, nd, $urandom_range(0, 4) != 0,
           $urandom_range(0, 29) == 0);
    end
    repeat (4) idle();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dec_monitor.md
DEC_MONITOR -- requirements
Module: dec_monitor

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all state SHALL be rising-edge clocked.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 dec_out  input  8  decoder true outputs, bit i = line i.
REQ-005 not_dec_out  input  8  decoder complement outputs.
REQ-006 en  input  1  decoder enable that accompanies the sample.
REQ-007 sample  input  1  one-cycle strobe; inputs are captured when high.
REQ-008 clr_err  input  1  synchronous clear of error count, sticky flag and hit map.
REQ-009 code  output  3  binary index of the lowest set dec_out bit; 0 when none is set.
REQ-010 code_valid  output  1  one-cycle pulse when code and the flags are valid.
REQ-011 active  output  1  at least one dec_out bit was set in the reported sample.
REQ-012 err_pair  output  1  dec_out != ~not_dec_out in the reported sample.
REQ-013 err_onehot  output  1  line-count violation in the reported sample.
REQ-014 err_cnt  output  8  saturating count of erroneous samples.
REQ-015 sticky_err  output  1  set by any error and held until clr_err or rst.
REQ-016 hit_map  output  8  bit i set once code i is reported with en=1 and no error.
REQ-017 sweep_done  output  1  hit_map == 8'hFF.

Function
REQ-018 Stage 1 SHALL register dec_out, not_dec_out and en when sample=1; a stage-1 valid bit SHALL follow sample.
REQ-019 Stage 2 SHALL compute code, active, err_pair and err_onehot from the stage-1 registers and assert code_valid exactly 2 cycles after the sample cycle.
REQ-020 Back-to-back samples SHALL be accepted every cycle with no stall; each sample SHALL produce exactly one code_valid pulse.
REQ-021 err_pair SHALL be 1 if any bit i has dec_out[i] == not_dec_out[i].
REQ-022 With en=1, err_onehot SHALL be 1 when popcount(dec_out) != 1.
REQ-023 With en=0, err_onehot SHALL be 1 when dec_out != 8'h00; the expected idle pattern is dec_out=8'h00, not_dec_out=8'hFF.
REQ-024 code, active, err_pair and err_onehot SHALL hold their last reported values between code_valid pulses.
REQ-025 A sample is erroneous when err_pair | err_onehot; err_cnt SHALL increment by 1 on the code_valid cycle of an erroneous sample.
REQ-026 err_cnt SHALL saturate at 8'hFF and never wrap.
REQ-027 sticky_err SHALL set on the code_valid cycle of an erroneous sample.
REQ-028 hit_map[code] SHALL set on the code_valid cycle of a sample with en=1 and no error.
REQ-029 sweep_done SHALL be combinational from hit_map.
REQ-030 If clr_err coincides with an update, clr_err SHALL win: err_cnt=0, sticky_err=0, hit_map=0 after that edge, and the coincident update SHALL be dropped.
REQ-031 clr_err SHALL NOT flush samples already in the pipeline; they SHALL report normally afterwards.

Reset
REQ-032 When rst=1, all outputs and pipeline valid bits SHALL clear asynchronously to 0: code=0, code_valid=0, active=0, err_pair=0, err_onehot=0, err_cnt=0, sticky_err=0, hit_map=0, sweep_done=0.
REQ-033 Samples in flight when rst asserts SHALL be discarded, with no code_valid pulse after release.
REQ-034 The first sample accepted after rst deasserts SHALL report 2 cycles later.

Verification
REQ-035 Sample dec_out=8'h20, not_dec_out=8'hDF, en=1 -> 2 cycles later: code_valid=1, code=5, active=1, both errors 0, hit_map[5]=1.
REQ-036 Sample dec_out=8'h00, not_dec_out=8'hFF, en=0 -> code=0, active=0, no errors, err_cnt unchanged, hit_map unchanged.
REQ-037 Sample dec_out=8'h03, not_dec_out=8'hFC, en=1 -> err_onehot=1, err_pair=0, code=0, err_cnt+1, sticky_err=1; then dec_out=8'h01, not_dec_out=8'hFF -> err_pair=1.
REQ-038 Eight consecutive-cycle samples sweeping codes 0..7 with en=1 -> eight code_valid pulses in order, hit_map=8'hFF, sweep_done=1.
REQ-039 Send 300 erroneous samples, then clr_err coinciding with an error report -> err_cnt reaches 8'hFF and stays there; after the clr_err edge err_cnt=0 and sticky_err=0.
REQ-040 Assert rst asynchronously one cycle after a sample -> all outputs are 0 immediately, and no code_valid pulse follows.
